tetris_game_ctrl: RTL and testbench

- Drives the playfield engine's command side: turns raw button levels into single-cycle move pulses, a rotation index and a gravity tick, and selects the next piece.
- Consumes the engine's `next_block`, `score_plus` and `gameover` outputs.
- Runs the game FSM (idle / spawn / fall / lock / over) and accumulates score and level.
- Sits between the keyboard/button front end and the field engine.

---
 rtl/tetris_game_ctrl_if.sv | 38 +++
 rtl/tetris_game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_game_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tetris_game_ctrl_if
//  Brief    : Command/status bundle between the button front end, the game
//             controller and the playfield engine.
//  Revision : 1.0  initial release
// ============================================================================
interface tetris_game_ctrl_if;
    logic        btn_left;
    logic        btn_right;
    logic        btn_down;
    logic        btn_rot;
    logic        next_block;
    logic [9:0]  score_plus;
    logic        gameover;
    logic        left;
    logic        right;
    logic        down;
    logic [9:0]  ro;
    logic [9:0]  block_num;
    logic [15:0] score;
    logic [3:0]  level;
    logic        playing;

    modport master (
        output btn_left, btn_right, btn_down, btn_rot,
        output next_block, score_plus, gameover,
        input  left, right, down, ro, block_num, score, level, playing
    );

    modport slave (
        input  btn_left, btn_right, btn_down, btn_rot,
        input  next_block, score_plus, gameover,
        output left, right, down, ro, block_num, score, level, playing
    );
endinterface
`default_nettype wire

// File: rtl/tetris_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tetris_game_ctrl
//  Brief    : Game FSM: button edge detection, move arbitration, gravity,
//             piece selection, score and level accounting.
//  Revision : 1.0  initial release
// ============================================================================
module tetris_game_ctrl #(
    parameter int unsigned GRAV_BASE = 16,
    parameter int unsigned GRAV_STEP = 2,
    parameter int unsigned GRAV_MIN  = 4,
    parameter int unsigned LEVEL_PTS = 10,
    parameter logic [7:0]  LFSR_SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    tetris_game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_btn_prev;
    logic        r_pend_l;
    logic        r_pend_r;
    logic        r_pend_d;
    logic        r_pend_rot;
    logic        r_grav_req;
    logic [15:0] r_grav_cnt;
    logic [7:0]  r_lfsr;
    logic [1:0]  r_ro;
    logic [2:0]  r_blk;
    logic [15:0] r_score;
    logic [3:0]  r_level;
    logic [15:0] r_lvl_acc;
    logic [9:0]  r_pts;
    logic        r_left;
    logic        r_right;
    logic        r_down;

    logic [3:0]  w_btn;
    logic [3:0]  w_rise;
    logic        w_lfsr_fb;
    logic [15:0] w_grav_dec;
    logic [15:0] w_period;
    logic        w_grav_tick;
    logic [2:0]  w_blk_nxt;
    logic [16:0] w_score_sum;
    logic [16:0] w_acc_sum;
    logic        w_do_left;
    logic        w_do_right;
    logic        w_do_down;
    logic        w_do_rot;

    assign w_btn     = {bus.btn_rot, bus.btn_down, bus.btn_right, bus.btn_left};
    assign w_rise    = w_btn & ~r_btn_prev;
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Level-derived gravity period, clamped so high levels never go below the floor.
    assign w_grav_dec  = 16'(r_level) * 16'(GRAV_STEP);
    assign w_period    = (16'(GRAV_BASE) >= w_grav_dec + 16'(GRAV_MIN)) ?
                         (16'(GRAV_BASE) - w_grav_dec) : 16'(GRAV_MIN);
    // >= rather than == so a period shrinking mid-count cannot stall gravity.
    assign w_grav_tick = (r_state == S_FALL) && (r_grav_cnt >= w_period - 16'd1);

    assign w_blk_nxt   = (r_lfsr[2:0] != 3'd7) ? r_lfsr[2:0] :
                         (r_blk == 3'd6) ? 3'd0 : r_blk + 3'd1;
    assign w_score_sum = {1'b0, r_score} + {7'd0, r_pts};
    assign w_acc_sum   = {1'b0, r_lvl_acc} + {7'd0, r_pts};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_left   = 1'b0;
        w_do_right  = 1'b0;
        w_do_down   = 1'b0;
        w_do_rot    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_rise) begin
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_state_nxt = S_FALL;
            end
            S_FALL: begin
                w_do_rot = r_pend_rot;
                if (bus.gameover) begin
                    w_state_nxt = S_OVER;
                end else if (bus.next_block) begin
                    w_state_nxt = S_LOCK;
                end else if (r_grav_req || r_pend_d) begin
                    w_do_down = 1'b1;
                end else if (r_pend_l) begin
                    w_do_left = 1'b1;
                end else if (r_pend_r) begin
                    w_do_right = 1'b1;
                end
            end
            S_LOCK: begin
                w_state_nxt = S_SPAWN;
            end
            S_OVER: begin
                if (w_rise[3]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 4'd0;
            r_pend_l   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_pend_d   <= 1'b0;
            r_pend_rot <= 1'b0;
            r_grav_req <= 1'b0;
            r_grav_cnt <= 16'd0;
            r_lfsr     <= LFSR_SEED;
            r_ro       <= 2'd0;
            r_blk      <= 3'd0;
            r_score    <= 16'd0;
            r_level    <= 4'd0;
            r_lvl_acc  <= 16'd0;
            r_pts      <= 10'd0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_down     <= 1'b0;
        end else begin
            r_btn_prev <= w_btn;
            r_left     <= w_do_left;
            r_right    <= w_do_right;
            r_down     <= w_do_down;

            if (r_state != S_IDLE) begin
                r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            end

            // A fresh edge wins over consumption so a re-press is never lost.
            if (r_state == S_FALL) begin
                r_pend_l   <= (r_pend_l & ~w_do_left) | w_rise[0];
                r_pend_r   <= (r_pend_r & ~w_do_right) | w_rise[1];
                r_pend_d   <= (r_pend_d & ~w_do_down) | w_rise[2];
                r_pend_rot <= (r_pend_rot & ~w_do_rot) | w_rise[3];
                r_grav_req <= (r_grav_req & ~w_do_down) | w_grav_tick;
                r_grav_cnt <= w_grav_tick ? 16'd0 : r_grav_cnt + 16'd1;
            end else begin
                r_pend_l   <= 1'b0;
                r_pend_r   <= 1'b0;
                r_pend_d   <= 1'b0;
                r_pend_rot <= 1'b0;
                r_grav_req <= 1'b0;
                r_grav_cnt <= 16'd0;
            end

            if (r_state == S_SPAWN) begin
                r_ro  <= 2'd0;
                r_blk <= w_blk_nxt;
            end else if (w_do_rot) begin
                r_ro <= r_ro + 2'd1;
            end

            if ((r_state == S_FALL) && (w_state_nxt == S_LOCK)) begin
                r_pts <= bus.score_plus;
            end

            case (r_state)
                S_LOCK: begin
                    r_score   <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                    r_lvl_acc <= w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
                end
                S_OVER: begin
                    if (w_rise[3]) begin
                        r_score   <= 16'd0;
                        r_level   <= 4'd0;
                        r_lvl_acc <= 16'd0;
                    end
                end
                default: begin
                    if (r_lvl_acc >= 16'(LEVEL_PTS)) begin
                        r_lvl_acc <= r_lvl_acc - 16'(LEVEL_PTS);
                        if (r_level != 4'd15) begin
                            r_level <= r_level + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.left      = r_left;
    assign bus.right     = r_right;
    assign bus.down      = r_down;
    assign bus.ro        = {8'd0, r_ro};
    assign bus.block_num = {7'd0, r_blk};
    assign bus.score     = r_score;
    assign bus.level     = r_level;
    assign bus.playing   = (r_state == S_SPAWN) || (r_state == S_FALL) || (r_state == S_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tetris_game_ctrl
//  Brief    : Self-checking bench for tetris_game_ctrl with a game-level
//             reference model and directed corner-case sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tetris_game_ctrl;

    localparam int GRAV_BASE = 16;
    localparam int GRAV_STEP = 2;
    localparam int GRAV_MIN  = 4;
    localparam int LEVEL_PTS = 10;
    localparam int MD_IDLE   = 0;
    localparam int MD_SPAWN  = 1;
    localparam int MD_FALL   = 2;
    localparam int MD_LOCK   = 3;
    localparam int MD_OVER   = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       nb;
    logic [9:0] sp;
    logic       go;
    int         n_checks;
    int         n_fail;

    tetris_game_ctrl_if bus ();

    assign bus.btn_left   = btn[0];
    assign bus.btn_right  = btn[1];
    assign bus.btn_down   = btn[2];
    assign bus.btn_rot    = btn[3];
    assign bus.next_block = nb;
    assign bus.score_plus = sp;
    assign bus.gameover   = go;

    tetris_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game-level view: mode, outstanding requests (0=L 1=R 2=D 3=rot), counters.
    typedef struct packed {
        int         mode;
        logic [3:0] prev;
        logic [3:0] req;
        logic       grav;
        int         cnt;
        logic [7:0] lfsr;
        int         ro;
        int         blk;
        int         score;
        int         level;
        int         acc;
        int         pts;
        logic       left;
        logic       right;
        logic       down;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r      = '0;
        r.mode = MD_IDLE;
        r.lfsr = 8'h01;
        return r;
    endfunction

    function automatic model_t model_next(model_t s, logic [3:0] b, logic nbk, logic [9:0] pts, logic gov);
        model_t     n;
        logic [3:0] rise;
        int         period;
        n       = s;
        rise    = b & ~s.prev;
        n.prev  = b;
        n.left  = 1'b0;
        n.right = 1'b0;
        n.down  = 1'b0;
        if (s.mode != MD_IDLE) n.lfsr = {s.lfsr[6:0], ^(s.lfsr & 8'hB8)};
        if (s.mode != MD_FALL) begin
            n.req  = 4'd0;
            n.grav = 1'b0;
            n.cnt  = 0;
        end
        if (s.mode != MD_LOCK && s.mode != MD_OVER && s.acc >= LEVEL_PTS) begin
            n.acc   = s.acc - LEVEL_PTS;
            n.level = (s.level < 15) ? s.level + 1 : 15;
        end
        case (s.mode)
            MD_IDLE: if (rise != 4'd0) n.mode = MD_SPAWN;
            MD_SPAWN: begin
                n.mode = MD_FALL;
                n.ro   = 0;
                n.blk  = (int'(s.lfsr[2:0]) == 7) ? (s.blk + 1) % 7 : int'(s.lfsr[2:0]);
            end
            MD_FALL: begin
                period = GRAV_BASE - s.level * GRAV_STEP;
                if (period < GRAV_MIN) period = GRAV_MIN;
                if (gov) n.mode = MD_OVER;
                else if (nbk) begin
                    n.mode = MD_LOCK;
                    n.pts  = int'(pts);
                end else if (s.grav || s.req[2]) begin
                    n.down   = 1'b1;
                    n.grav   = 1'b0;
                    n.req[2] = 1'b0;
                end else if (s.req[0]) begin
                    n.left   = 1'b1;
                    n.req[0] = 1'b0;
                end else if (s.req[1]) begin
                    n.right  = 1'b1;
                    n.req[1] = 1'b0;
                end
                if (s.req[3]) begin
                    n.ro     = (s.ro + 1) % 4;
                    n.req[3] = 1'b0;
                end
                n.req = n.req | rise;
                if (s.cnt >= period - 1) begin
                    n.cnt  = 0;
                    n.grav = 1'b1;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
            MD_LOCK: begin
                n.mode  = MD_SPAWN;
                n.score = (s.score + s.pts > 65535) ? 65535 : s.score + s.pts;
                n.acc   = (s.acc + s.pts > 65535) ? 65535 : s.acc + s.pts;
            end
            MD_OVER: begin
                if (rise[3]) begin
                    n.mode  = MD_IDLE;
                    n.score = 0;
                    n.level = 0;
                    n.acc   = 0;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, btn, nb, sp, go);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        logic exp_play;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_play = (m.mode == MD_SPAWN) || (m.mode == MD_FALL) || (m.mode == MD_LOCK);
            n_checks++;
            if (bus.left !== m.left || bus.right !== m.right || bus.down !== m.down ||
                bus.ro !== 10'(m.ro) || bus.block_num !== 10'(m.blk) ||
                bus.score !== 16'(m.score) || bus.level !== 4'(m.level) ||
                bus.playing !== exp_play) begin
                n_fail++;
                $display("FAIL model t=%0t got lrd=%b%b%b ro=%0d blk=%0d score=%0d lvl=%0d play=%b expected lrd=%b%b%b ro=%0d blk=%0d score=%0d lvl=%0d play=%b",
                         $time, bus.left, bus.right, bus.down, bus.ro, bus.block_num, bus.score,
                         bus.level, bus.playing, m.left, m.right, m.down, m.ro, m.blk, m.score,
                         m.level, exp_play);
            end
        end
    endtask

    task automatic start_game();
        btn[0] = 1'b1;
        cyc(1);
        chk("start_spawn_playing", bus.playing, 1);
        cyc(1);
        btn[0] = 1'b0;
    endtask

    task automatic land(input int pts, input int settle);
        nb = 1'b1;
        sp = 10'(pts);
        cyc(1);
        nb = 1'b0;
        cyc(settle);
    endtask

    task automatic wait_down();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(1);
            if (bus.down) seen = 1'b1;
        end
        chk("down_within_bound", seen, 1);
    endtask

    task automatic measure_period(input string nm, input int exp);
        int k;
        wait_down();
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            cyc(1);
            if (bus.down) k = i;
        end
        chk(nm, k, exp);
    endtask

    typedef struct {
        logic [9:0]  pts;
        logic [15:0] exp_score;
        logic [3:0]  exp_level;
    } lock_vec_t;

    lock_vec_t vecs [0:4];

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{10'd25, 16'd25,  4'd2};
        vecs[1] = '{10'd5,  16'd30,  4'd3};
        vecs[2] = '{10'd0,  16'd30,  4'd3};
        vecs[3] = '{10'd70, 16'd100, 4'd10};
        vecs[4] = '{10'd64, 16'd164, 4'd15};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn      = 4'd0;
        nb       = 1'b0;
        sp       = 10'd0;
        go       = 1'b0;
        cyc(3);
        chk("rst_playing", bus.playing, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_block", bus.block_num, 0);
        chk("rst_moves", {bus.left, bus.right, bus.down}, 0);
        rst_n = 1'b1;
        cyc(2);

        // First piece comes straight from the seed; the start press is not a move.
        start_game();
        chk("first_block", bus.block_num, 1);
        chk("first_ro", bus.ro, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (bus.left) seen = 1'b1;
        end
        chk("start_no_left", seen, 0);
        measure_period("grav_period_lvl0", 16);

        land(60, 10);
        chk("level_after_60", bus.level, 6);
        measure_period("grav_period_lvl6", 4);
        land(10, 6);
        chk("level_after_70", bus.level, 7);
        measure_period("grav_period_lvl7", 4);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_playing", bus.playing, 0);
        chk("arst_score", bus.score, 0);
        chk("arst_level", bus.level, 0);
        chk("arst_block", bus.block_num, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Left+right edges landing on the same edge as a gravity tick.
        start_game();
        wait_down();
        cyc(14);
        btn = 4'b0011;
        cyc(2);
        btn = 4'b0000;
        chk("tie_down_first", bus.down, 1);
        chk("tie_no_left_yet", bus.left, 0);
        cyc(1);
        chk("tie_left_second", bus.left, 1);
        chk("tie_down_cleared", bus.down, 0);
        cyc(1);
        chk("tie_right_third", bus.right, 1);

        for (int i = 1; i <= 4; i++) begin
            btn[3] = 1'b1;
            cyc(1);
            btn[3] = 1'b0;
            cyc(1);
            chk("rot_step", bus.ro, i % 4);
        end
        btn[3] = 1'b1;
        cyc(50);
        btn[3] = 1'b0;
        cyc(2);
        chk("rot_hold_once", bus.ro, 1);

        for (int i = 0; i < 5; i++) begin
            land(int'(vecs[i].pts), int'(vecs[i].pts) / 10 + 4);
            chk("vec_score", bus.score, vecs[i].exp_score);
            chk("vec_level", bus.level, vecs[i].exp_level);
            chk("vec_playing", bus.playing, 1);
        end

        // gameover outranks next_block: no score added.
        go = 1'b1;
        nb = 1'b1;
        sp = 10'd50;
        cyc(1);
        go = 1'b0;
        nb = 1'b0;
        chk("over_playing", bus.playing, 0);
        chk("over_score", bus.score, 164);
        btn[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            btn[0] = 1'b0;
            if (bus.left || bus.right || bus.down) seen = 1'b1;
        end
        chk("over_no_moves", seen, 0);
        chk("over_level_frozen", bus.level, 15);
        btn[3] = 1'b1;
        cyc(1);
        btn[3] = 1'b0;
        chk("restart_score", bus.score, 0);
        chk("restart_level", bus.level, 0);
        chk("restart_playing", bus.playing, 0);
        cyc(1);

        start_game();
        for (int i = 0; i < 65; i++) land(1000, 2);
        land(520, 4);
        chk("score_fff0", bus.score, 16'hFFF0);
        land(100, 4);
        chk("score_saturate", bus.score, 16'hFFFF);

        for (int c = 0; c < 3000; c++) begin
            int gh;
            if (c == 0) gh = 0;
            if ($urandom_range(0, 5) == 0) begin
                int idx;
                idx      = int'($urandom_range(0, 3));
                btn[idx] = ~btn[idx];
            end
            nb = ($urandom_range(0, 15) == 0);
            sp = 10'($urandom_range(0, 300));
            if (gh > 0) gh--;
            else if ($urandom_range(0, 299) == 0) gh = 3;
            go = (gh > 0);
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
